// File: rtl/control_botones.sv
// Pushbutton conditioner: per-button synchronize, debounce and arm, then
// derive one-cycle action pulses plus the test / acelerar level toggles.

module control_botones_lane #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic primed_i,
    input  logic btn_n_i,
    output logic pressed_o,
    output logic armed_o,
    output logic press_o
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          s;
    logic          d_q, d_d;
    logic          dp_q;
    logic          a_q, a_d;
    logic [CW-1:0] c_q, c_d;

    assign s = sync_q[1];

    always_comb begin
        d_d = d_q;
        c_d = '0;
        if (s != d_q) begin
            if (c_q == C_LAST) begin
                d_d = s;
                c_d = '0;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    // Arming waits until the synchronizer holds real samples, otherwise its
    // reset value would arm a button that is being held through reset.
    assign a_d = a_q | (primed_i & s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            d_q    <= 1'b1;
            dp_q   <= 1'b1;
            c_q    <= '0;
            a_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
            d_q    <= d_d;
            dp_q   <= d_q;
            c_q    <= c_d;
            a_q    <= a_d;
        end
    end

    assign pressed_o = ~d_q;
    assign armed_o   = a_q;
    assign press_o   = a_q & dp_q & ~d_q;
endmodule

module control_botones #(
    parameter int DEB_CYCLES  = 50000,
    parameter int LONG_CYCLES = 250000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_comer_n,
    input  logic btn_jugar_n,
    input  logic btn_descansar_n,
    input  logic btn_test_n,
    input  logic btn_acel_n,
    output logic comer,
    output logic jugar,
    output logic descansar,
    output logic test,
    output logic acelerar
);
    localparam int NB  = 5;
    localparam int B_C = 0;
    localparam int B_J = 1;
    localparam int B_D = 2;
    localparam int B_T = 3;
    localparam int B_A = 4;
    localparam int HW  = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    logic [NB-1:0] btn_n, pressed, armed, press;
    logic [1:0]    prime_q;
    logic          comer_q, comer_d, jugar_q, jugar_d, desc_q, desc_d;
    logic          test_q, test_d, acel_q, acel_d, fired_q, fired_d;
    logic [HW-1:0] h_q, h_d;

    assign btn_n = {btn_acel_n, btn_test_n, btn_descansar_n, btn_jugar_n, btn_comer_n};

    for (genvar i = 0; i < NB; i++) begin : g_lane
        control_botones_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .primed_i  (prime_q[1]),
            .btn_n_i   (btn_n[i]),
            .pressed_o (pressed[i]),
            .armed_o   (armed[i]),
            .press_o   (press[i])
        );
    end

    always_comb begin
        comer_d = press[B_C];
        jugar_d = press[B_J] & ~press[B_C];
        desc_d  = press[B_D] & ~press[B_J] & ~press[B_C];
        acel_d  = acel_q ^ press[B_A];
        test_d  = test_q;
        h_d     = h_q;
        fired_d = fired_q;
        // h saturates; fired_q keeps a long hold from toggling more than once.
        if (pressed[B_T] && armed[B_T]) begin
            if (h_q != H_LAST) begin
                h_d = h_q + 1'b1;
            end else if (!fired_q) begin
                test_d  = ~test_q;
                fired_d = 1'b1;
            end
        end else if (!pressed[B_T]) begin
            h_d     = '0;
            fired_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_q <= 2'b00;
            comer_q <= 1'b0;
            jugar_q <= 1'b0;
            desc_q  <= 1'b0;
            test_q  <= 1'b0;
            acel_q  <= 1'b0;
            fired_q <= 1'b0;
            h_q     <= '0;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
            comer_q <= comer_d;
            jugar_q <= jugar_d;
            desc_q  <= desc_d;
            test_q  <= test_d;
            acel_q  <= acel_d;
            fired_q <= fired_d;
            h_q     <= h_d;
        end
    end

    assign comer     = comer_q;
    assign jugar     = jugar_q;
    assign descansar = desc_q;
    assign test      = test_q;
    assign acelerar  = acel_q;
endmodule

// File: tb/tb_control_botones.sv
// Directed bench for control_botones with DEB_CYCLES=4, LONG_CYCLES=20.

module tb_control_botones;
    logic clk = 1'b0;
    logic rst;
    logic btn_comer_n, btn_jugar_n, btn_descansar_n, btn_test_n, btn_acel_n;
    logic comer, jugar, descansar, test, acelerar;
    logic [4:0] outs;
    int n_cmp = 0;
    int n_err = 0;
    int n_comer = 0, n_jugar = 0, n_desc = 0;
    int b_comer, b_jugar, b_desc;

    control_botones #(.DEB_CYCLES(4), .LONG_CYCLES(20)) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_comer_n     (btn_comer_n),
        .btn_jugar_n     (btn_jugar_n),
        .btn_descansar_n (btn_descansar_n),
        .btn_test_n      (btn_test_n),
        .btn_acel_n      (btn_acel_n),
        .comer           (comer),
        .jugar           (jugar),
        .descansar       (descansar),
        .test            (test),
        .acelerar        (acelerar)
    );

    always #5 clk = ~clk;

    assign outs = {acelerar, test, descansar, jugar, comer};

    always @(negedge clk) begin
        if (comer)     n_comer++;
        if (jugar)     n_jugar++;
        if (descansar) n_desc++;
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_comer = n_comer;
        b_jugar = n_jugar;
        b_desc  = n_desc;
    endtask

    initial begin
        rst = 1'b0;
        {btn_comer_n, btn_jugar_n, btn_descansar_n, btn_test_n, btn_acel_n} = 5'b11111;

        // Reset and idle
        ticks(3);
        chk("rst_outs", int'(outs), 0);
        rst = 1'b1;
        chk("rst_release", int'(outs), 0);
        snap();
        ticks(50);
        chk("idle_outs", int'(outs), 0);
        chk("idle_pulses", (n_comer - b_comer) + (n_jugar - b_jugar) + (n_desc - b_desc), 0);

        // Clean comer press: pulse visible after edge t0+6
        snap();
        btn_comer_n = 1'b0;
        ticks(6);  chk("comer_pre", int'(outs), 0);
        ticks(1);  chk("comer_pulse", int'(outs), 5'b00001);
        ticks(1);  chk("comer_post", int'(outs), 0);
        ticks(23);
        btn_comer_n = 1'b1;
        ticks(20);
        chk("comer_cnt", n_comer - b_comer, 1);
        chk("comer_others", (n_jugar - b_jugar) + (n_desc - b_desc), 0);

        // Bounce on jugar, then a clean hold
        snap();
        btn_jugar_n = 1'b0; ticks(1);
        btn_jugar_n = 1'b1; ticks(1);
        btn_jugar_n = 1'b0; ticks(1);
        btn_jugar_n = 1'b0; ticks(1);
        btn_jugar_n = 1'b1; ticks(1);
        btn_jugar_n = 1'b0;
        ticks(6);  chk("jugar_pre", int'(outs), 0);
        ticks(1);  chk("jugar_pulse", int'(outs), 5'b00010);
        ticks(1);  chk("jugar_post", int'(outs), 0);
        ticks(20);
        btn_jugar_n = 1'b1;
        ticks(20);
        chk("jugar_cnt", n_jugar - b_jugar, 1);

        // 3-cycle glitch is rejected
        snap();
        btn_jugar_n = 1'b0; ticks(3);
        btn_jugar_n = 1'b1; ticks(20);
        chk("glitch_cnt", n_jugar - b_jugar, 0);

        // Simultaneous comer + descansar: comer wins, descansar dropped
        snap();
        btn_comer_n = 1'b0;
        btn_descansar_n = 1'b0;
        ticks(7);  chk("simul_pulse", int'(outs), 5'b00001);
        ticks(1);  chk("simul_post", int'(outs), 0);
        ticks(15);
        btn_comer_n = 1'b1;
        btn_descansar_n = 1'b1;
        ticks(20);
        chk("simul_comer", n_comer - b_comer, 1);
        chk("simul_desc", n_desc - b_desc, 0);

        // Lone descansar press
        snap();
        btn_descansar_n = 1'b0;
        ticks(7);  chk("desc_pulse", int'(outs), 5'b00100);
        ticks(10);
        btn_descansar_n = 1'b1;
        ticks(20);
        chk("desc_cnt", n_desc - b_desc, 1);

        // Long press of 40 cycles toggles test at edge t0+25, once
        btn_test_n = 1'b0;
        ticks(25); chk("test_pre", int'(test), 0);
        ticks(1);  chk("test_on", int'(outs), 5'b01000);
        ticks(14); chk("test_hold", int'(test), 1);
        btn_test_n = 1'b1;
        ticks(20); chk("test_rel", int'(test), 1);
        // 15-cycle hold is too short
        btn_test_n = 1'b0; ticks(15);
        btn_test_n = 1'b1; ticks(20);
        chk("test_short", int'(test), 1);
        // 30-cycle hold toggles back
        btn_test_n = 1'b0;
        ticks(25); chk("test2_pre", int'(test), 1);
        ticks(1);  chk("test2_off", int'(test), 0);
        ticks(4);
        btn_test_n = 1'b1;
        ticks(20); chk("test2_rel", int'(outs), 0);

        // acelerar toggles on press only
        btn_acel_n = 1'b0;
        ticks(6);  chk("acel1_pre", int'(acelerar), 0);
        ticks(1);  chk("acel1_on", int'(acelerar), 1);
        ticks(5);
        btn_acel_n = 1'b1;
        ticks(20); chk("acel1_rel", int'(acelerar), 1);
        btn_acel_n = 1'b0;
        ticks(7);  chk("acel2_off", int'(acelerar), 0);
        ticks(5);
        btn_acel_n = 1'b1;
        ticks(20); chk("acel2_rel", int'(acelerar), 0);

        // Reset clears acelerar; comer held through reset stays silent
        btn_acel_n = 1'b0;
        ticks(10); chk("acel3_on", int'(acelerar), 1);
        btn_acel_n = 1'b1;
        ticks(20);
        btn_comer_n = 1'b0;
        ticks(3);
        rst = 1'b0;
        #1;
        chk("rst_async", int'(outs), 0);
        ticks(3);
        rst = 1'b1;
        snap();
        ticks(30);
        chk("held_nopulse", n_comer - b_comer, 0);
        chk("held_outs", int'(outs), 0);
        btn_comer_n = 1'b1;
        ticks(20);
        snap();
        btn_comer_n = 1'b0;
        ticks(6);  chk("rearm_pre", int'(outs), 0);
        ticks(1);  chk("rearm_pulse", int'(outs), 5'b00001);
        ticks(1);  chk("rearm_post", int'(outs), 0);
        btn_comer_n = 1'b1;
        ticks(20);
        chk("rearm_cnt", n_comer - b_comer, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
